// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the LED pattern engine and its prescaler.
package led_pattern_pkg;

  // Pattern select values as presented on the mode switches.
  typedef enum logic [1:0] {
    ROTATE = 2'd0,
    BOUNCE = 2'd1,
    FILL   = 2'd2,
    BLINK  = 2'd3
  } led_mode_e;

  // Widest LED bank the seed helper can describe; callers cast down to their width.
  localparam int LED_MAX_W = 256;

  // Starting pattern for a mode: one-hot MSB for the moving-dot modes,
  // empty bar for FILL, all lit for BLINK.
  function automatic logic [LED_MAX_W-1:0] led_seed(input led_mode_e mode, input int width);
    logic [LED_MAX_W-1:0] seed;
    seed = '0;
    case (mode)
      ROTATE, BOUNCE: seed = {{(LED_MAX_W-1){1'b0}}, 1'b1} << (width - 1);
      FILL:           seed = '0;
      BLINK:          seed = ~({LED_MAX_W{1'b1}} << width);
      default:        seed = '0;
    endcase
    return seed;
  endfunction

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// Prescaler producing a one-cycle enable every DIV enabled clock cycles.
// Freezing en holds the count so a paused period resumes where it stopped.
module tick_gen #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Terminal count detection and wrap/hold of the prescaler.
  always_comb begin
    tick  = en && (cnt_q == CNT_W'(DIV - 1));
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Prescaler register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: rotate, bounce, fill-bar and blink on a single board
// clock, advanced by a prescaler tick instead of a derived clock.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIV   = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             step
);

  localparam logic [WIDTH-1:0] ONE_HOT_MSB = WIDTH'(led_seed(ROTATE, WIDTH));

  logic             tick;
  led_mode_e        modeSel;
  logic [WIDTH-1:0] led_q, led_d;
  led_mode_e        mode_q, mode_d;
  logic             bdir_q, bdir_d;
  logic             step_q;

  tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  assign modeSel = led_mode_e'(mode);

  // Next pattern: reseed on a mode change, otherwise advance per the held mode.
  always_comb begin
    led_d  = led_q;
    mode_d = mode_q;
    bdir_d = bdir_q;
    if (tick) begin
      if (modeSel != mode_q) begin
        mode_d = modeSel;
        led_d  = WIDTH'(led_seed(modeSel, WIDTH));
        bdir_d = dir;
      end else begin
        case (mode_q)
          ROTATE: begin
            if (dir) begin
              led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
            end else begin
              led_d = {led_q[0], led_q[WIDTH-1:1]};
            end
          end
          BOUNCE: begin
            // Turn around at an end in the same tick so no position dwells.
            if (!bdir_q) begin
              if (led_q[0]) begin
                bdir_d = 1'b1;
                led_d  = led_q << 1;
              end else begin
                led_d  = led_q >> 1;
              end
            end else begin
              if (led_q[WIDTH-1]) begin
                bdir_d = 1'b0;
                led_d  = led_q >> 1;
              end else begin
                led_d  = led_q << 1;
              end
            end
          end
          FILL: begin
            if (&led_q) begin
              led_d = '0;
            end else if (dir) begin
              led_d = {led_q[WIDTH-2:0], 1'b1};
            end else begin
              led_d = {1'b1, led_q[WIDTH-1:1]};
            end
          end
          BLINK: begin
            led_d = ~led_q;
          end
          default: begin
            led_d = led_q;
          end
        endcase
      end
    end
  end

  // Pattern, mode, bounce direction and step pulse registers; reset wins over a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q  <= ONE_HOT_MSB;
      mode_q <= ROTATE;
      bdir_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      mode_q <= mode_d;
      bdir_q <= bdir_d;
      step_q <= tick;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule
